// File: rtl/briskv_mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM between instruction fetch (port 0)
// and the data path (port 1). One access per cycle; read data is routed back to the issuer.
module briskv_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  input  logic [3:0]            p0_wmask,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  input  logic [3:0]            p1_wmask,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [31:0]           p1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_ren,
  input  logic [31:0]           mem_rdata
);

  logic last_gnt_q, last_gnt_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // Pretend port 1 won last so port 0 takes the first contention.
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!RESET) begin
      if (p0_req && p1_req) begin
        if (FIXED_PRIO != 0) begin
          p1_gnt = 1'b1;
        end else if (last_gnt_q) begin
          p0_gnt = 1'b1;
        end else begin
          p1_gnt = 1'b1;
        end
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = p1_gnt ? p1_addr : p0_addr;
    mem_wdata = p1_gnt ? p1_wdata : p0_wdata;
    mem_wmask = 4'b0000;
    if (p0_gnt) begin
      mem_wmask = p0_wmask;
    end else if (p1_gnt) begin
      mem_wmask = p1_wmask;
    end
    mem_ren = (p0_gnt && (p0_wmask == 4'b0000)) || (p1_gnt && (p1_wmask == 4'b0000));
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (p0_gnt) begin
      last_gnt_d = 1'b0;
    end else if (p1_gnt) begin
      last_gnt_d = 1'b1;
    end
    rd_pend_d  = mem_ren;
    rd_owner_d = mem_ren ? p1_gnt : rd_owner_q;
  end

  // RESET masks a return still in flight from the grant just before it.
  always_comb begin
    p0_rvalid = !RESET && rd_pend_q && !rd_owner_q;
    p1_rvalid = !RESET && rd_pend_q && rd_owner_q;
    p0_rdata  = mem_rdata;
    p1_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_briskv_mem_arbiter.sv
// Directed bench for briskv_mem_arbiter: a round-robin instance driving a small RAM model and a
// fixed-priority instance sharing the same request inputs.
module tb_briskv_mem_arbiter;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p1_req;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic [3:0]    p0_wmask, p1_wmask;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0]   p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;
  logic          mem_ren;

  logic          f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid;
  logic [31:0]   f_p0_rdata, f_p1_rdata;
  logic [AW-1:0] f_mem_addr;
  logic [31:0]   f_mem_wdata;
  logic [3:0]    f_mem_wmask;
  logic          f_mem_ren;

  logic [31:0]   ram [0:15];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  briskv_mem_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0)) u_dut (
    .CLK(clk), .RESET(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata)
  );

  briskv_mem_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1)) u_fix (
    .CLK(clk), .RESET(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask),
    .mem_ren(f_mem_ren), .mem_rdata(32'hCAFE_0000)
  );

  // Single-port synchronous RAM model, 1-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wmask[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_ren) mem_rdata <= ram[mem_addr[3:0]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    p0_req = 1'b0; p1_req = 1'b0;
    p0_wmask = 4'b0000; p1_wmask = 4'b0000;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    p1_req = 1'b1; p1_addr = a; p1_wdata = d; p1_wmask = 4'b1111;
    tick();
    idle();
  endtask

  task automatic test_reset;
    p0_req = 1'b1; p1_req = 1'b1; p0_addr = 1; p1_addr = 2;
    @(negedge clk);
    n_checks++;
    if ({p0_gnt, p1_gnt, f_p0_gnt, f_p1_gnt} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt got %b want 0000", {p0_gnt, p1_gnt, f_p0_gnt, f_p1_gnt});
    end
    n_checks++;
    if ({p0_rvalid, p1_rvalid, mem_ren} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rvalid_ren got %b want 000", {p0_rvalid, p1_rvalid, mem_ren});
    end
    n_checks++;
    if (mem_wmask !== 4'b0000) begin
      n_fail++; $display("FAIL reset_wmask got %b want 0000", mem_wmask);
    end
    tick();
    idle();
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    p0_req = 1'b1; p0_addr = 5; p0_wmask = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({p0_gnt, p1_gnt, mem_ren} !== 3'b101 || mem_addr !== AW'(5)) begin
      n_fail++;
      $display("FAIL single_read_gnt gnt0/gnt1/ren got %b addr %0d want 101 addr 5",
               {p0_gnt, p1_gnt, mem_ren}, mem_addr);
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_read_data rvalid %b data %h want 10 deadbeef",
               {p0_rvalid, p1_rvalid}, p0_rdata);
    end
    tick();
  endtask

  task automatic test_byte_write;
    p1_req = 1'b1; p1_addr = 7; p1_wdata = 32'h0000_00AA; p1_wmask = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (p1_gnt !== 1'b1 || mem_wmask !== 4'b0001 || mem_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_write_gnt gnt %b wmask %b ren %b want 1 0001 0", p1_gnt, mem_wmask, mem_ren);
    end
    tick();
    p1_wmask = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00 || p1_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_write_no_rvalid rvalid %b gnt %b want 00 1", {p0_rvalid, p1_rvalid}, p1_gnt);
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h1122_33AA) begin
      n_fail++; $display("FAIL byte_write_read rvalid %b data %h want 1 112233aa", p1_rvalid, p1_rdata);
    end
    tick();
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_data;
    do_reset();
    p0_req = 1'b1; p0_addr = 1; p1_req = 1'b1; p1_addr = 2;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) idle();
      @(negedge clk);
      if (i < 6) begin
        n_checks++;
        if ({p0_gnt, p1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rr_gnt cycle %0d got %b", i, {p0_gnt, p1_gnt});
        end
      end
      if (i > 0) begin
        exp_data = ((i - 1) % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
        n_checks++;
        if ({p0_rvalid, p1_rvalid} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01) ||
            mem_rdata !== exp_data) begin
          n_fail++;
          $display("FAIL rr_rvalid cycle %0d rvalid %b data %h want data %h",
                   i, {p0_rvalid, p1_rvalid}, mem_rdata, exp_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_fixed_prio;
    p0_req = 1'b1; p0_addr = 1; p1_req = 1'b1; p1_addr = 2; p1_wdata = 32'h5A5A_0001;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) p1_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({f_p0_gnt, f_p1_gnt} !== ((i < 3) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL fixed_gnt cycle %0d got %b", i, {f_p0_gnt, f_p1_gnt});
      end
      if (i == 1) begin
        n_checks++;
        if (f_mem_addr !== AW'(2) || f_mem_wdata !== 32'h5A5A_0001 || f_mem_ren !== 1'b1 ||
            f_mem_wmask !== 4'b0000) begin
          n_fail++;
          $display("FAIL fixed_mem addr %0d wdata %h ren %b wmask %b", f_mem_addr, f_mem_wdata,
                   f_mem_ren, f_mem_wmask);
        end
        n_checks++;
        if ({f_p0_rvalid, f_p1_rvalid} !== 2'b01 || f_p1_rdata !== 32'hCAFE_0000 ||
            f_p0_rdata !== 32'hCAFE_0000) begin
          n_fail++;
          $display("FAIL fixed_rvalid rvalid %b data %h want 01 cafe0000",
                   {f_p0_rvalid, f_p1_rvalid}, f_p1_rdata);
        end
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_read;
    p0_req = 1'b1; p0_addr = 3;
    @(negedge clk);
    n_checks++;
    if (p0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midreset_gnt got %b want 1", p0_gnt);
    end
    tick();
    idle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_rvalid got %b want 00", {p0_rvalid, p1_rvalid});
    end
    tick();
    rst = 1'b0;
    p0_req = 1'b1; p0_addr = 0; p1_req = 1'b1; p1_addr = 1;
    @(negedge clk);
    n_checks++;
    if ({p0_gnt, p1_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_first_gnt got %b want 10", {p0_gnt, p1_gnt});
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1000_0000) begin
      n_fail++; $display("FAIL midreset_data rvalid %b data %h want 1 10000000", p0_rvalid, p0_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [0:3];
    exp[0] = 32'h1000_0000; exp[1] = 32'h1111_1111; exp[2] = 32'h2222_2222; exp[3] = 32'h3333_3333;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        p0_req = 1'b1; p0_addr = AW'(i); p0_wmask = 4'b0000;
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 4) begin
        n_checks++;
        if (p0_gnt !== 1'b1 || mem_ren !== 1'b1) begin
          n_fail++; $display("FAIL b2b_gnt cycle %0d gnt %b ren %b want 1 1", i, p0_gnt, mem_ren);
        end
      end
      if (i > 0) begin
        n_checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== exp[i-1]) begin
          n_fail++;
          $display("FAIL b2b_data cycle %0d rvalid %b data %h want 1 %h", i, p0_rvalid, p0_rdata,
                   exp[i-1]);
        end
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (p0_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_tail rvalid got %b want 0", p0_rvalid);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    idle();
    tick();
    tick();
    test_reset();
    preload(0, 32'h1000_0000);
    preload(1, 32'h1111_1111);
    preload(2, 32'h2222_2222);
    preload(3, 32'h3333_3333);
    preload(5, 32'hDEAD_BEEF);
    preload(7, 32'h1122_3344);
    tick();
    test_single_read();
    test_byte_write();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
